// File: rtl/jk_reg_bank.sv
// jk_reg_bank: a bank of WIDTH JK flip-flops sharing one clock.
// Every mode (JK, D load, masked toggle, up/down count) is expressed as
// an effective per-bit J/K pair feeding the same JK next-state logic.
// The bank also provides a synchronous clear, a hold enable, a
// combinational terminal-count flag, a sticky wrap flag and a delayed
// change pulse.
//
// Handshake note: the block has no valid/ready interface. Inputs are
// sampled on every rising clock edge. Outputs are valid for the whole
// cycle that follows that edge.
module jk_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             up,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             tc,
  output logic             wrap,
  output logic             changed
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_D     = 2'b01;
  localparam logic [1:0] MODE_T     = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  logic [WIDTH-1:0] cnt_t;     // per-bit toggle enable of the counter
  logic [WIDTH-1:0] j_eff;     // effective J after mode mapping
  logic [WIDTH-1:0] k_eff;     // effective K after mode mapping
  logic [WIDTH-1:0] q_next;    // JK next state for an enabled edge
  logic             at_end;    // Q is at the wrap point for the direction
  logic             chg_pend;  // this edge changed Q; shown on the next edge

  // Ripple toggle chain: a bit flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    cnt_t    = '0;
    cnt_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      cnt_t[i] = cnt_t[i-1] & (up ? Q[i-1] : ~Q[i-1]);
    end
  end

  // Wrap point detection and the cascadable terminal-count output.
  always_comb begin
    at_end = up ? (&Q) : ~(|Q);
    tc     = (mode == MODE_COUNT) & en & ~sclr & at_end;
  end

  // Map the selected mode onto per-bit J/K inputs.
  always_comb begin
    j_eff = '0;
    k_eff = '0;
    case (mode)
      MODE_JK: begin
        j_eff = J;
        k_eff = K;
      end
      MODE_D: begin
        j_eff = J;
        k_eff = ~J;
      end
      MODE_T: begin
        j_eff = J;
        k_eff = J;
      end
      MODE_COUNT: begin
        j_eff = cnt_t;
        k_eff = cnt_t;
      end
      default: begin
        j_eff = '0;
        k_eff = '0;
      end
    endcase
  end

  // JK characteristic per bit: hold, reset, set, toggle.
  always_comb begin
    q_next = Q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j_eff[i], k_eff[i]})
        2'b00:   q_next[i] = Q[i];
        2'b01:   q_next[i] = 1'b0;
        2'b10:   q_next[i] = 1'b1;
        default: q_next[i] = ~Q[i];
      endcase
    end
  end

  // State register.
  // Priority: async reset, then sclr, then hold on en=0, then the mode update.
  // The change pulse is delayed twice, so 'changed' appears one edge after Q moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q        <= RST_VAL;
      wrap     <= 1'b0;
      chg_pend <= 1'b0;
      changed  <= 1'b0;
    end else begin
      changed <= chg_pend;
      if (sclr) begin
        Q        <= '0;
        wrap     <= 1'b0;
        chg_pend <= |Q;
      end else if (!en) begin
        chg_pend <= 1'b0;
      end else begin
        Q        <= q_next;
        chg_pend <= (q_next != Q);
        if ((mode == MODE_COUNT) && at_end) begin
          wrap <= 1'b1;
        end
      end
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank (WIDTH=4, RST_VAL=0).
// The reference model is written with plain arithmetic and set/clear masks.
module tb_jk_reg_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sclr;
  logic [1:0] mode;
  logic [3:0] J;
  logic [3:0] K;
  logic       up;
  logic [3:0] Q;
  logic [3:0] Qn;
  logic       tc;
  logic       wrap;
  logic       changed;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [3:0] q_m;
  logic       w_m;
  logic       cp_m;  // last edge changed Q
  logic       ch_m;  // expected 'changed'

  jk_reg_bank #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .sclr(sclr), .mode(mode),
    .J(J), .K(K), .up(up), .Q(Q), .Qn(Qn), .tc(tc), .wrap(wrap),
    .changed(changed)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one comparison
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    logic [3:0] qn_exp;
    qn_exp = ~q_m;
    check("q", Q, q_m);
    check("qn", Qn, qn_exp);
    check("wrap", wrap, w_m);
    check("changed", changed, ch_m);
  endtask

  // Drive one cycle of inputs, check tc, clock it, and check the result.
  task automatic step(input logic e, input logic s, input logic [1:0] m,
                      input logic [3:0] j, input logic [3:0] k, input logic u);
    logic [3:0] nq;
    logic       nw;
    logic       tc_exp;
    @(negedge clk);
    en = e; sclr = s; mode = m; J = j; K = k; up = u;
    #1;
    tc_exp = (m == 2'd3) && e && !s && (u ? (q_m == 4'hF) : (q_m == 4'h0));
    check("tc", tc, tc_exp);
    @(posedge clk);
    #1;
    nq = q_m;
    nw = w_m;
    if (s) begin
      nq = 4'h0;
      nw = 1'b0;
    end else if (e) begin
      case (m)
        2'd0: nq = ((q_m | (j & ~k)) & ~(k & ~j)) ^ (j & k);
        2'd1: nq = j;
        2'd2: nq = q_m ^ j;
        default: begin
          nq = u ? q_m + 4'd1 : q_m - 4'd1;
          if (u ? (q_m == 4'hF) : (q_m == 4'h0)) nw = 1'b1;
        end
      endcase
    end
    ch_m = cp_m;
    cp_m = (nq != q_m);
    q_m  = nq;
    w_m  = nw;
    check_state();
  endtask

  task automatic model_reset();
    q_m = 4'h0; w_m = 1'b0; cp_m = 1'b0; ch_m = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; sclr = 1'b0; mode = 2'd0;
    J = 4'h0; K = 4'h0; up = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    rst = 1'b1;

    // JK mode: set, reset, toggle, hold per bit
    step(1, 0, 2'd1, 4'b0101, 4'h0, 0);
    step(1, 0, 2'd0, 4'b1010, 4'b0110, 0);
    check("jk_q", Q, 4'b1011);
    step(0, 0, 2'd0, 4'h0, 4'h0, 0);
    check("jk_changed", changed, 1'b1);

    // D mode load, repeated load, then hold with en=0
    step(1, 0, 2'd1, 4'h6, 4'h0, 0);
    step(1, 0, 2'd1, 4'h6, 4'h0, 0);
    check("d_q", Q, 4'h6);
    for (int i = 0; i < 3; i++) step(0, 0, 2'd1, 4'h9, 4'h0, 0);
    check("d_hold", Q, 4'h6);

    // count up across the wrap, then turn down at zero
    step(1, 0, 2'd1, 4'hE, 4'h0, 0);
    step(1, 0, 2'd3, 4'h0, 4'h0, 1);
    step(1, 0, 2'd3, 4'h0, 4'h0, 1);
    check("wrap_set", wrap, 1'b1);
    step(1, 0, 2'd3, 4'h0, 4'h0, 0);
    check("down_q", Q, 4'hF);

    // sclr beats en=0 and clears wrap; sclr at zero is no change
    step(0, 1, 2'd3, 4'h0, 4'h0, 1);
    check("sclr_q", Q, 4'h0);
    step(0, 1, 2'd3, 4'h0, 4'h0, 1);
    step(0, 0, 2'd0, 4'h0, 4'h0, 0);

    // T mode toggles twice
    step(1, 0, 2'd2, 4'b1001, 4'h0, 0);
    step(1, 0, 2'd2, 4'b1001, 4'h0, 0);
    step(0, 0, 2'd2, 4'h0, 4'h0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset between edges with Q=A and wrap set
    step(1, 0, 2'd1, 4'h0, 4'h0, 0);
    step(1, 0, 2'd3, 4'h0, 4'h0, 0);
    step(1, 0, 2'd1, 4'hA, 4'h0, 0);
    check("pre_rst_q", Q, 4'hA);
    check("pre_rst_wrap", wrap, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_state();
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    en = 1'b0; sclr = 1'b0;
    rst = 1'b1;
    step(1, 0, 2'd1, 4'h3, 4'h0, 0);
    step(1, 0, 2'd0, 4'h0, 4'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised bank of WIDTH JK flip-flops sharing one clock, with a per-cycle mode select: per-bit JK, parallel D-load, masked toggle, and synchronous up/down counting. It is the general-purpose sequential storage/count element for testbench-facing register blocks, replacing single-bit JK flops. It adds an enable, a synchronous clear, a terminal-count flag, a sticky wrap flag and a one-cycle change pulse.

## Interface
Parameters:
- WIDTH, 8, number of flops in the bank; legal values are 2 and above.
- RST_VAL, '0, WIDTH-bit value loaded into Q on reset.

Ports:
- clk  input  1  clock; all state updates on the posedge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  update enable; 0 holds all state except for sclr.
- sclr  input  1  synchronous clear; takes priority over en and mode.
- mode  input  2  00 JK, 01 D, 10 T, 11 COUNT.
- J  input  WIDTH  JK set bits (JK mode), load data (D mode), toggle mask (T mode), ignored in COUNT.
- K  input  WIDTH  JK reset bits (JK mode only), ignored otherwise.
- up  input  1  count direction in COUNT mode: 1 up, 0 down.
- Q  output  WIDTH  registered bank state.
- Qn  output  WIDTH  always ~Q.
- tc  output  1  terminal count (combinational).
- wrap  output  1  sticky flag, set when a count wraps.
- changed  output  1  registered pulse: Q changed on the previous edge.

## Operation
- Reset (rst=0, asynchronous, applied immediately and independent of clk):
  - Q=RST_VAL, Qn=~RST_VAL.
  - wrap=0, changed=0.
  - tc follows its formula from Q.
- Release of rst is synchronised by the bench; the first update occurs on the first posedge with rst=1.
- Priority at each posedge: sclr, then en=0 (hold), then mode.
- sclr=1 sets Q=0 and wrap=0, regardless of en or mode.
- en=0 and sclr=0: Q and wrap hold.
- JK mode, per bit i:
  - J=0, K=0: hold.
  - J=0, K=1: 0.
  - J=1, K=0: 1.
  - J=1, K=1: toggle.
- D mode: Q=J.
- T mode: Q=Q^J.
- COUNT mode:
  - Q=Q+1 when up=1, Q=Q-1 when up=0, modulo 2^WIDTH.
  - Realised as JK flops with J_i=K_i = AND of the lower bits (up) or the lower inverted bits (down).
  - Wrap-around: all-ones to 0 (up) or 0 to all-ones (down) sets wrap=1.
  - wrap stays set until sclr or rst.
  - If the wrap edge is also a sclr edge, sclr wins and wrap=0.
- tc = (mode==COUNT) & en & ~sclr & (up ? Q=={WIDTH{1'b1}} : Q==0).
- changed:
  - Goes to 1 on the edge after any edge where the new Q differs from the old Q, from any source including sclr.
  - Otherwise 0.
  - It is never set by reset.
- mode may change on any cycle. Each edge uses only that edge's sampled mode; no state is carried between modes.

## Timing
- Inputs are sampled at the posedge. Q, Qn and wrap are valid one clock after the sampling edge, with no additional pipeline.
- changed lags the Q update by one clock (two edges after the causing stimulus).
- tc is combinational from Q and the current inputs. It is valid in the same cycle it predicts the wrap, so it can be cascaded into the next bank's en.
- Reset asserted mid-cycle overrides an in-flight update. The posedge coincident with rst=0 performs no update.

## Test plan
All scenarios use WIDTH=4 and RST_VAL=0.
- Reset mid-operation: set Q=4'hA, wrap=1, then drive rst=0 between edges. Required: Q=0, Qn=4'hF, wrap=0 and changed=0 before the next posedge, and they stay there while rst=0.
- JK mode: Q=4'b0101, J=4'b1010, K=4'b0110, en=1. Required next edge: Q=4'b1011 (set, reset, toggle, hold per bit), then changed=1 for one cycle.
- D mode: J=4'h6 gives Q=6 and changed=1. Holding J=4'h6 a second edge gives Q=6 and changed=0. With en=0 and J=4'h9 for 3 edges, Q stays 6.
- Count up from 4'hE:
  - Sequence E, F, 0; tc=1 only while Q=F.
  - wrap=1 from the edge that loads 0 and stays set.
  - Switching to up=0 at Q=0 gives tc=1, and the next edge gives Q=F.
- sclr priority: in COUNT mode at Q=F with up=1, en=0 and sclr=1. Required next edge: Q=0, wrap=0, tc=0 during that cycle. sclr at Q=0 gives changed=0.
- T mode: from Q=0, J=4'b1001 gives Q=4'b1001, then Q=0 on the next edge. changed=1 after each edge.
